// File: rtl/counter_cmd_seq.sv
// Command sequencer for a 4-bit loadable up/down counter.
// It accepts LOAD / UP N / DOWN N / HOLD N commands over a valid/ready handshake.
// It drives the counter's load, data and updown inputs so the counter either
// steps, loads, or holds its value.
module counter_cmd_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_value,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [3:0]       cnt_q,
  output logic             load,
  output logic [3:0]       data,
  output logic             updown,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE,
    EXEC
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_HOLD = 2'b11
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [3:0]       value_q, value_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;

  // State and command registers; reset aborts any running command without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      value_q <= 4'h0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      value_q <= value_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: latch a command in IDLE, count down the remaining cycles in EXEC.
  // A zero-length UP/DOWN/HOLD runs as a single HOLD cycle so the counter never steps.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    value_d = value_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = EXEC;
          value_d = cmd_value;
          if ((cmd_op != OP_LOAD) && (cmd_len == '0)) begin
            op_d  = OP_HOLD;
            rem_d = LEN_W'(1);
          end else begin
            op_d  = op_e'(cmd_op);
            rem_d = cmd_len;
          end
        end
      end
      EXEC: begin
        if ((op_q == OP_LOAD) || (rem_q <= LEN_W'(1))) begin
          state_d = IDLE;
          rem_d   = '0;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - LEN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter controls decoded from registered state; IDLE and HOLD feed the count back to freeze it
  always_comb begin
    load      = 1'b1;
    data      = cnt_q;
    updown    = 1'b0;
    cmd_ready = (state_q == IDLE);
    busy      = (state_q == EXEC);
    done      = done_q;
    if (state_q == EXEC) begin
      case (op_q)
        OP_LOAD: begin
          data = value_q;
        end
        OP_UP: begin
          load   = 1'b0;
          updown = 1'b1;
          data   = value_q;
        end
        OP_DOWN: begin
          load = 1'b0;
          data = value_q;
        end
        default: begin
          load = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/counter_cmd_seq.md
# counter_cmd_seq

Command sequencer that sits directly upstream of the 4-bit loadable up/down counter and drives its `load`, `data` and `updown` inputs. It accepts commands over a valid/ready handshake: LOAD, count UP N, count DOWN N, or HOLD N cycles. It reads the counter's output back on `cnt_q` so it can freeze the counter. The counter otherwise steps on every non-load cycle, so this block is the only way to make it pause.

## Interface
- `LEN_W`, default 8: width of the command length field.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  operation: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- `cmd_value`  in  4  load value; used by LOAD only.
- `cmd_len`  in  LEN_W  number of execute cycles for UP/DOWN/HOLD; ignored for LOAD.
- `cnt_q`  in  4  counter `data_out` feedback.
- `load`  out  1  to counter `load`.
- `data`  out  4  to counter `data`.
- `updown`  out  1  to counter `updown`; 1 means up.
- `busy`  out  1  a command is executing.
- `done`  out  1  one-cycle pulse marking command completion.

## Operation
- States: IDLE and EXEC. The `op`, `value` and `rem` (LEN_W bits) registers are latched on acceptance.
- IDLE:
  - `cmd_ready`=1, `busy`=0.
  - Drives HOLD: `load`=1, `data`=`cnt_q`, `updown`=0, so the counter keeps its value.
- Accept occurs when `cmd_valid` && `cmd_ready` at a rising edge. The FSM moves to EXEC and latches `op`, `value`, and `rem`=`cmd_len`.
- EXEC outputs by op:
  - LOAD: `load`=1, `data`=`value`, `updown`=0.
  - UP: `load`=0, `updown`=1, `data`=`value` (don't-care).
  - DOWN: `load`=0, `updown`=0.
  - HOLD: `load`=1, `data`=`cnt_q`, `updown`=0.
- EXEC sequencing:
  - `cmd_ready`=0, `busy`=1.
  - LOAD lasts exactly 1 cycle.
  - UP/DOWN/HOLD last `rem` cycles. `rem` decrements each EXEC cycle, and the FSM returns to IDLE on the edge where `rem`==1.
- `cmd_len`=0 for UP/DOWN/HOLD:
  - Executes 1 cycle with HOLD outputs, so no count step occurs.
  - `done` still pulses.
- `done`: registered. It is 1 for exactly the first IDLE cycle after EXEC ends and is never asserted otherwise.
- Wrap-around belongs to the counter (modulo 16). The sequencer does no arithmetic on the count value.
- Only one command is in flight at a time; there is no queuing. `cmd_*` inputs are ignored while `cmd_ready`=0.
- Reset:
  - The FSM goes to IDLE and `rem`=0.
  - Reset values: `cmd_ready`=1, `busy`=0, `done`=0, `load`=1, `updown`=0, `data`=`cnt_q`.
  - Reset mid-EXEC aborts the command with no `done` pulse. Reset has priority over acceptance on the same edge.

## Timing
- `cmd_ready`, `busy`, `load`, `updown` and the `data` source select are decoded from registered state only. `data` is combinational from `cnt_q` in HOLD and IDLE.
- Accept at edge T:
  - EXEC outputs are valid from T to T+N (N = execute cycles, ≥1).
  - The counter applies them at edges T+1 … T+N.
  - `done`=1 and `cmd_ready`=1 during T+N to T+N+1.
- The next command can be accepted at edge T+N+1. Back-to-back throughput is therefore N+1 cycles per command; the extra cycle is an IDLE hold cycle.
- UP/DOWN N: the counter changes by exactly ±N mod 16.

## Test plan
- Reset, then idle 5 cycles with the counter attached and holding 0 → `cnt_q` stays 0, `load`=1, `cmd_ready`=1, `done`=0.
- LOAD 0xE, then UP `cmd_len`=3 → `cnt_q` goes 0xE, 0xF, 0x0, 0x1 and holds at 0x1. `done` pulses once per command. Acceptances are 2 cycles apart.
- LOAD 0x2, then DOWN `cmd_len`=4 → `cnt_q` goes 0x1, 0x0, 0xF, 0xE and holds at 0xE.
- LOAD 0x5, then HOLD `cmd_len`=6 → `cnt_q`=0x5 for all cycles and `busy`=1 for 6 cycles. UP `cmd_len`=0 → `cnt_q` remains 0x5, `busy` for 1 cycle, `done` pulses.
- `cmd_valid` held high with a new op while busy → the op is not accepted until `cmd_ready`=1. Exactly one acceptance per command is confirmed by the scoreboard.
- `rst` asserted on the 2nd cycle of UP `cmd_len`=10 → next cycle is IDLE with `busy`=0, no `done` pulse, and the counter held. A following LOAD 0x9 executes normally.
